// File: rtl/axi4s_rr_arbiter.sv
// axi4s_rr_arbiter: N:1 AXI4-Stream arbiter, round-robin and packet-locked.
// The grant is taken in IDLE and held until the owner's tlast beat handshakes.
module axi4s_rr_arbiter #(
   parameter int NR_OF_SLAVES_P   = 4,
   parameter int AXI_DATA_WIDTH_P = 32,
   parameter int AXI_STRB_WIDTH_P = 4,
   parameter int AXI_KEEP_WIDTH_P = 4,
   parameter int AXI_ID_WIDTH_P   = 2,
   parameter int AXI_DEST_WIDTH_P = 2,
   parameter int AXI_USER_WIDTH_P = 1,
   localparam int GNT_WIDTH_P     = $clog2(NR_OF_SLAVES_P)
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [NR_OF_SLAVES_P-1:0]                    s_tvalid,
   output logic [NR_OF_SLAVES_P-1:0]                    s_tready,
   input  logic [NR_OF_SLAVES_P*AXI_DATA_WIDTH_P-1:0]   s_tdata,
   input  logic [NR_OF_SLAVES_P*AXI_STRB_WIDTH_P-1:0]   s_tstrb,
   input  logic [NR_OF_SLAVES_P*AXI_KEEP_WIDTH_P-1:0]   s_tkeep,
   input  logic [NR_OF_SLAVES_P-1:0]                    s_tlast,
   input  logic [NR_OF_SLAVES_P*AXI_ID_WIDTH_P-1:0]     s_tid,
   input  logic [NR_OF_SLAVES_P*AXI_DEST_WIDTH_P-1:0]   s_tdest,
   input  logic [NR_OF_SLAVES_P*AXI_USER_WIDTH_P-1:0]   s_tuser,
   output logic                                         m_tvalid,
   input  logic                                         m_tready,
   output logic [AXI_DATA_WIDTH_P-1:0]                  m_tdata,
   output logic [AXI_STRB_WIDTH_P-1:0]                  m_tstrb,
   output logic [AXI_KEEP_WIDTH_P-1:0]                  m_tkeep,
   output logic                                         m_tlast,
   output logic [AXI_ID_WIDTH_P-1:0]                    m_tid,
   output logic [AXI_DEST_WIDTH_P-1:0]                  m_tdest,
   output logic [AXI_USER_WIDTH_P-1:0]                  m_tuser,
   output logic [GNT_WIDTH_P-1:0]                       m_gnt,
   output logic                                         m_busy
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   localparam logic [GNT_WIDTH_P-1:0] LAST_IDX =
      GNT_WIDTH_P'(NR_OF_SLAVES_P - 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [GNT_WIDTH_P-1:0]  gnt_q;
   logic [GNT_WIDTH_P-1:0]  gnt_d;
   logic [GNT_WIDTH_P-1:0]  ptr_q;
   logic [GNT_WIDTH_P-1:0]  ptr_d;

   logic                    req_found;
   logic [GNT_WIDTH_P-1:0]  req_idx;
   logic [GNT_WIDTH_P-1:0]  cand;
   int                      idx;

   logic [AXI_DATA_WIDTH_P-1:0] data_a [NR_OF_SLAVES_P];
   logic [AXI_STRB_WIDTH_P-1:0] strb_a [NR_OF_SLAVES_P];
   logic [AXI_KEEP_WIDTH_P-1:0] keep_a [NR_OF_SLAVES_P];
   logic [AXI_ID_WIDTH_P-1:0]   id_a   [NR_OF_SLAVES_P];
   logic [AXI_DEST_WIDTH_P-1:0] dest_a [NR_OF_SLAVES_P];
   logic [AXI_USER_WIDTH_P-1:0] user_a [NR_OF_SLAVES_P];

   for (genvar i = 0; i < NR_OF_SLAVES_P; i++) begin : g_unpack
      assign data_a[i] = s_tdata[i*AXI_DATA_WIDTH_P +: AXI_DATA_WIDTH_P];
      assign strb_a[i] = s_tstrb[i*AXI_STRB_WIDTH_P +: AXI_STRB_WIDTH_P];
      assign keep_a[i] = s_tkeep[i*AXI_KEEP_WIDTH_P +: AXI_KEEP_WIDTH_P];
      assign id_a[i]   = s_tid[i*AXI_ID_WIDTH_P +: AXI_ID_WIDTH_P];
      assign dest_a[i] = s_tdest[i*AXI_DEST_WIDTH_P +: AXI_DEST_WIDTH_P];
      assign user_a[i] = s_tuser[i*AXI_USER_WIDTH_P +: AXI_USER_WIDTH_P];
   end

   // First requester at or after the pointer, wrapping; indices >= NR never appear.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand      = '0;
      idx       = 0;
      for (int k = 0; k < NR_OF_SLAVES_P; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NR_OF_SLAVES_P) begin
            idx = idx - NR_OF_SLAVES_P;
         end
         cand = GNT_WIDTH_P'(idx);
         if (!req_found && s_tvalid[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      s_tready = '0;
      m_tvalid = 1'b0;
      m_busy   = 1'b0;
      m_tdata  = data_a[gnt_q];
      m_tstrb  = strb_a[gnt_q];
      m_tkeep  = keep_a[gnt_q];
      m_tlast  = s_tlast[gnt_q];
      m_tid    = id_a[gnt_q];
      m_tdest  = dest_a[gnt_q];
      m_tuser  = user_a[gnt_q];
      unique case (state_q)
         IDLE: begin
            if (req_found) begin
               gnt_d   = req_idx;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            m_busy          = 1'b1;
            m_tvalid        = s_tvalid[gnt_q];
            s_tready[gnt_q] = m_tready;
            if (m_tvalid && m_tready && m_tlast) begin
               state_d = IDLE;
               ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
            end
         end
      endcase
   end

   assign m_gnt = gnt_q;

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// tb_axi4s_rr_arbiter: random sources and sink against a packet-level
// round-robin reference model, plus a directed grant-order check.
module tb_axi4s_rr_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int KW  = 4;
   localparam int IW  = 2;
   localparam int DSW = 2;
   localparam int UW  = 1;
   localparam int GW  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    s_tvalid;
   logic [NR-1:0]    s_tready;
   logic [NR*DW-1:0] s_tdata;
   logic [NR*SW-1:0] s_tstrb;
   logic [NR*KW-1:0] s_tkeep;
   logic [NR-1:0]    s_tlast;
   logic [NR*IW-1:0] s_tid;
   logic [NR*DSW-1:0] s_tdest;
   logic [NR*UW-1:0] s_tuser;
   logic             m_tvalid;
   logic             m_tready;
   logic [DW-1:0]    m_tdata;
   logic [SW-1:0]    m_tstrb;
   logic [KW-1:0]    m_tkeep;
   logic             m_tlast;
   logic [IW-1:0]    m_tid;
   logic [DSW-1:0]   m_tdest;
   logic [UW-1:0]    m_tuser;
   logic [GW-1:0]    m_gnt;
   logic             m_busy;

   axi4s_rr_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tdata  (s_tdata),
      .s_tstrb  (s_tstrb),
      .s_tkeep  (s_tkeep),
      .s_tlast  (s_tlast),
      .s_tid    (s_tid),
      .s_tdest  (s_tdest),
      .s_tuser  (s_tuser),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tdata  (m_tdata),
      .m_tstrb  (m_tstrb),
      .m_tkeep  (m_tkeep),
      .m_tlast  (m_tlast),
      .m_tid    (m_tid),
      .m_tdest  (m_tdest),
      .m_tuser  (m_tuser),
      .m_gnt    (m_gnt),
      .m_busy   (m_busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Source beat currently presented (held until accepted)
   logic          vld [NR];
   logic          lst [NR];
   logic [DW-1:0] dat [NR];
   logic [12:0]   side [NR];
   int            left [NR];

   // Reference: owner=-1 means no packet in flight
   int owner;
   int ptr;
   int gnt_reg;

   int p_start;
   int p_ready;
   int p_rst;
   int plen;
   bit log_en;
   int order_q[$];

   task automatic drive(input logic r, input logic rdy);
      rst      = r;
      m_tready = rdy;
      for (int i = 0; i < NR; i++) begin
         s_tvalid[i]             = vld[i];
         s_tlast[i]              = lst[i];
         s_tdata[i*DW +: DW]     = dat[i];
         s_tstrb[i*SW +: SW]     = side[i][12:9];
         s_tkeep[i*KW +: KW]     = side[i][8:5];
         s_tid[i*IW +: IW]       = side[i][4:3];
         s_tdest[i*DSW +: DSW]   = side[i][2:1];
         s_tuser[i*UW +: UW]     = side[i][0];
      end
   endtask

   task automatic cycle();
      logic          r;
      logic          rdy;
      logic          exp_v;
      logic [NR-1:0] exp_rdy;
      int            exp_g;
      bit            hs;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (!vld[i] && $urandom_range(99) < p_start) begin
            if (left[i] == 0) begin
               left[i] = (plen != 0) ? plen : $urandom_range(5, 1);
            end
            vld[i]  = 1'b1;
            lst[i]  = (left[i] == 1);
            dat[i]  = $urandom;
            side[i] = 13'($urandom);
         end
      end
      rdy = ($urandom_range(99) < p_ready);
      r   = ($urandom_range(999) < p_rst);
      drive(r, rdy);
      #1;
      exp_v   = (owner >= 0) ? vld[owner] : 1'b0;
      exp_rdy = '0;
      if (owner >= 0 && rdy) exp_rdy[owner] = 1'b1;
      exp_g   = (owner >= 0) ? owner : gnt_reg;
      check("m_tvalid", 64'(m_tvalid), 64'(exp_v));
      check("s_tready", 64'(s_tready), 64'(exp_rdy));
      check("m_busy", 64'(m_busy), 64'(owner >= 0));
      check("m_gnt", 64'(m_gnt), 64'(exp_g));
      if (exp_v) begin
         check("m_tdata", 64'(m_tdata), 64'(dat[owner]));
         check("m_tlast", 64'(m_tlast), 64'(lst[owner]));
         check("m_side", 64'({m_tstrb, m_tkeep, m_tid, m_tdest, m_tuser}),
               64'(side[owner]));
      end
      if (log_en && m_busy && m_tvalid && m_tready && m_tlast) begin
         order_q.push_back(int'(m_gnt));
      end
      hs = (owner >= 0) && vld[owner] && rdy;
      if (r) begin
         owner   = -1;
         ptr     = 0;
         gnt_reg = 0;
      end else if (owner < 0) begin
         for (int k = 0; k < NR; k++) begin
            if (owner < 0 && vld[(ptr + k) % NR]) begin
               owner   = (ptr + k) % NR;
               gnt_reg = owner;
            end
         end
      end else if (hs && lst[owner]) begin
         ptr   = (owner + 1) % NR;
         owner = -1;
      end
      if (hs) begin
         vld[gnt_reg] = 1'b0;
         left[gnt_reg]--;
      end
   endtask

   initial begin
      int exp_order [5];
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NR; i++) begin
         vld[i]  = 1'b0;
         lst[i]  = 1'b0;
         dat[i]  = '0;
         side[i] = '0;
         left[i] = 0;
      end
      owner   = -1;
      ptr     = 0;
      gnt_reg = 0;
      log_en  = 1'b0;
      drive(1'b1, 1'b0);
      repeat (3) @(posedge clk);

      // Reset then idle, no requests
      p_start = 0;
      p_ready = 50;
      p_rst   = 0;
      plen    = 0;
      repeat (20) cycle();

      // All sources busy with 2-beat packets, sink always ready
      p_start = 100;
      p_ready = 100;
      plen    = 2;
      log_en  = 1'b1;
      repeat (20) cycle();
      log_en  = 1'b0;
      check("order_len", 64'(order_q.size() >= 5), 64'(1));
      for (int k = 0; k < 5 && k < order_q.size(); k++) begin
         check($sformatf("order%0d", k), 64'(order_q[k]), 64'(exp_order[k]));
      end

      // Random traffic with sink backpressure and source gaps
      plen    = 0;
      p_start = 40;
      p_ready = 60;
      repeat (2000) cycle();

      // Sparse requests, toggling sink, occasional reset pulses
      p_start = 15;
      p_ready = 50;
      p_rst   = 20;
      repeat (2000) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
